rf_fsk_tx: RTL and testbench
============================

RF_FSK_TX -- requirements
Module: rf_fsk_tx

Interface
REQ-001 Parameter ACC_W, 24, width of the tone and carrier phase accumulators and of the tuning words.
REQ-002 Parameter BPS, 1, bits per symbol; legal values are 1, 2 and 4; the tone count is 2^BPS.
REQ-003 Parameter SYM_CNT, 3333, clock cycles per symbol; minimum value is 2.
REQ-004 Parameter FIFO_DEPTH, 4, byte FIFO depth; must be a power of two and at least 2.
REQ-005 Parameter CARRIER_CW, 24'h400000, carrier tuning word.
REQ-006 Parameter TONE0_CW, 5033, reset value of tone table entry 0.
REQ-007 Parameter TONE_STEP_CW, 4194, reset increment between consecutive tone table entries.
REQ-008 clk  in  1  single system clock; all logic is clocked on its rising edge.
REQ-009 rst  in  1  synchronous, active-high reset.
REQ-010 in_data  in  8  byte to transmit.
REQ-011 in_valid  in  1  in_data is valid.
REQ-012 in_ready  out  1  FIFO can accept a byte.
REQ-013 cfg_we  in  1  tone table write strobe.
REQ-014 cfg_addr  in  BPS  tone table index.
REQ-015 cfg_data  in  ACC_W  tone tuning word.
REQ-016 rf  out  1  modulated RF bit.
REQ-017 busy  out  1  a byte is being serialised.
REQ-018 sym_stb  out  1  one-cycle pulse on the first cycle of each data symbol.
REQ-019 fifo_level  out  $clog2(FIFO_DEPTH)+1  number of bytes queued.

Function
REQ-020 Byte acceptance: a byte SHALL be accepted on a cycle where in_valid=1 and in_ready=1.
REQ-021 in_ready SHALL equal NOT full.
REQ-022 A push and a pop on the same cycle, when the FIFO is not full, SHALL leave fifo_level unchanged.
REQ-023 The block SHALL have exactly two states: IDLE and SEND.
REQ-024 IDLE with fifo_level>0 SHALL pop the FIFO head into a shift register, enter SEND on the next cycle, and assert sym_stb on that first SEND cycle.
REQ-025 Each byte SHALL be sent LSB first as 8/BPS symbols; the symbol index is the low BPS bits of the shift register.
REQ-026 Each symbol SHALL last exactly SYM_CNT cycles.
REQ-027 At the end of each symbol the shift register SHALL shift right by BPS, and sym_stb SHALL pulse on the first cycle of the next symbol.
REQ-028 After the last symbol of a byte: if the FIFO is non-empty, the next byte SHALL be popped with no gap cycle (back-to-back); otherwise the block SHALL return to IDLE.
REQ-029 busy SHALL be 1 exactly while the state is SEND.
REQ-030 The active tone index SHALL be 0 (mark) in IDLE and the current symbol index in SEND.
REQ-031 Every cycle, tone_acc SHALL be updated to tone_acc + tone[index] modulo 2^ACC_W; the update is phase-continuous with no reset at symbol boundaries.
REQ-032 Every cycle, car_acc SHALL be updated to car_acc + CARRIER_CW modulo 2^ACC_W.
REQ-033 rf SHALL be registered and equal to tone_acc[ACC_W-1] XOR car_acc[ACC_W-1].
REQ-034 cfg_we=1 SHALL write cfg_data to tone[cfg_addr]; the new word SHALL be used from the next cycle, including during an active symbol.

Reset
REQ-035 Reset SHALL clear the FIFO, giving fifo_level=0 and in_ready=1.
REQ-036 Reset SHALL set the state to IDLE with busy=0 and sym_stb=0.
REQ-037 Reset SHALL clear both accumulators, giving rf=0.
REQ-038 Reset SHALL load tone[k] with TONE0_CW + k*TONE_STEP_CW.
REQ-039 A reset asserted mid-byte SHALL abort the byte immediately; no symbol may be emitted after reset.

Verification
REQ-040 Bench parameters: BPS=1, SYM_CNT=4, FIFO_DEPTH=4. Push 0xA5 -> sym_stb fires 8 times, 4 cycles apart; the tone index sequence is 1,0,1,0,0,1,0,1; busy is high for 32 cycles, then the block returns to IDLE.
REQ-041 Push 5 bytes with in_valid held high and no pops -> in_ready goes low at fifo_level=4; the 5th byte is held until a slot is freed; all 5 bytes are sent back-to-back with no idle cycle between them.
REQ-042 With tone[0]=0, tone[1]=0 and CARRIER_CW=2^(ACC_W-2) -> rf toggles every 2 cycles; a cfg write tone[0]=2^(ACC_W-1) in IDLE -> tone_acc MSB toggles every cycle from the next cycle.
REQ-043 Assert rst for 1 cycle during the 3rd symbol of a byte -> busy=0, fifo_level=0, rf=0 on the following cycle, and no further sym_stb.
REQ-044 BPS=2: push 0x1B -> tone index sequence is 3,2,1,0, with a sym_stb per symbol.
REQ-045 Push and pop on the same cycle at fifo_level=2 -> fifo_level stays 2 and no byte is lost or duplicated.

Source files
------------

// File: rtl/rf_fsk_tx.sv
// Byte-serial M-FSK transmitter: FIFO -> symbol shifter -> phase-continuous tone NCO mixed with a carrier NCO.
// First symbol starts 2 cycles after a byte is accepted; in_ready drops only when the FIFO is full.

module rf_fsk_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_vld,
  input  logic [W-1:0]               wr_dat,
  output logic                       wr_rdy,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_dat,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          push, pop;

  always_comb begin
    push     = wr_vld && (level_q != (AW+1)'(DEPTH));
    pop      = rd_en && (level_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_dat;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      level_d = level_q + (AW+1)'(1);
    else if (!push && pop) level_d = level_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign wr_rdy = (level_q != (AW+1)'(DEPTH));
  assign rd_dat = mem_q[rd_ptr_q];
  assign level  = level_q;
endmodule

module rf_fsk_tx #(
  parameter int               ACC_W        = 24,
  parameter int               BPS          = 1,
  parameter int               SYM_CNT      = 3333,
  parameter int               FIFO_DEPTH   = 4,
  parameter logic [ACC_W-1:0] CARRIER_CW   = ACC_W'(24'h400000),
  parameter logic [ACC_W-1:0] TONE0_CW     = ACC_W'(5033),
  parameter logic [ACC_W-1:0] TONE_STEP_CW = ACC_W'(4194)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          cfg_we,
  input  logic [BPS-1:0]                cfg_addr,
  input  logic [ACC_W-1:0]              cfg_data,
  output logic                          rf,
  output logic                          busy,
  output logic                          sym_stb,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int NTONE = 1 << BPS;
  localparam int NSYM  = 8 / BPS;
  localparam int CW    = (SYM_CNT > 2) ? $clog2(SYM_CNT) : 1;
  localparam int SW    = $clog2(NSYM);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state_q, state_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [CW-1:0]    sym_cnt_q, sym_cnt_d;
  logic [SW-1:0]    sym_idx_q, sym_idx_d;
  logic             sym_stb_q, sym_stb_d;
  logic [ACC_W-1:0] tone_acc_q, tone_acc_d;
  logic [ACC_W-1:0] car_acc_q, car_acc_d;
  logic [ACC_W-1:0] tone_q [NTONE];
  logic [ACC_W-1:0] tone_d [NTONE];
  logic             rf_q, rf_d;
  logic [BPS-1:0]   tone_idx;
  logic             pop;
  logic [7:0]       head;
  logic             fifo_nonempty;

  rf_fsk_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (in_valid),
    .wr_dat (in_data),
    .wr_rdy (in_ready),
    .rd_en  (pop),
    .rd_dat (head),
    .level  (fifo_level)
  );

  assign fifo_nonempty = (fifo_level != '0);

  always_comb begin
    tone_idx  = (state_q == SEND) ? shreg_q[BPS-1:0] : '0;
    pop       = 1'b0;
    state_d   = state_q;
    shreg_d   = shreg_q;
    sym_cnt_d = sym_cnt_q;
    sym_idx_d = sym_idx_q;
    sym_stb_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_nonempty) begin
          pop       = 1'b1;
          shreg_d   = head;
          state_d   = SEND;
          sym_cnt_d = '0;
          sym_idx_d = '0;
          sym_stb_d = 1'b1;
        end
      end
      default: begin
        if (sym_cnt_q == CW'(SYM_CNT - 1)) begin
          sym_cnt_d = '0;
          if (sym_idx_q == SW'(NSYM - 1)) begin
            // Chain straight into the next byte so back-to-back bytes have no gap cycle.
            if (fifo_nonempty) begin
              pop       = 1'b1;
              shreg_d   = head;
              sym_idx_d = '0;
              sym_stb_d = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            shreg_d   = shreg_q >> BPS;
            sym_idx_d = sym_idx_q + SW'(1);
            sym_stb_d = 1'b1;
          end
        end else begin
          sym_cnt_d = sym_cnt_q + CW'(1);
        end
      end
    endcase

    tone_acc_d = tone_acc_q + tone_q[tone_idx];
    car_acc_d  = car_acc_q + CARRIER_CW;
    rf_d       = tone_acc_q[ACC_W-1] ^ car_acc_q[ACC_W-1];
    tone_d     = tone_q;
    if (cfg_we) tone_d[cfg_addr] = cfg_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      sym_cnt_q  <= '0;
      sym_idx_q  <= '0;
      sym_stb_q  <= 1'b0;
      tone_acc_q <= '0;
      car_acc_q  <= '0;
      rf_q       <= 1'b0;
      for (int k = 0; k < NTONE; k++) tone_q[k] <= TONE0_CW + ACC_W'(k) * TONE_STEP_CW;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      sym_cnt_q  <= sym_cnt_d;
      sym_idx_q  <= sym_idx_d;
      sym_stb_q  <= sym_stb_d;
      tone_acc_q <= tone_acc_d;
      car_acc_q  <= car_acc_d;
      rf_q       <= rf_d;
      tone_q     <= tone_d;
    end
  end

  assign busy    = (state_q == SEND);
  assign sym_stb = sym_stb_q;
  assign rf      = rf_q;
endmodule

// File: tb/tb_rf_fsk_tx.sv
// Bench for rf_fsk_tx: BPS=1 and BPS=2 instances checked every cycle against a symbol-timeline model.
module tb_rf_fsk_tx;
  localparam int          SYM   = 4;
  localparam int          DEPTH = 4;
  localparam logic [23:0] CAR   = 24'h400000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v      [2];
  logic [7:0]  in_data_v  [2];
  logic        in_valid_v [2];
  logic        cfg_we_v   [2];
  logic [1:0]  cfg_addr_v [2];
  logic [23:0] cfg_data_v [2];
  logic        rf_o       [2];
  logic        busy_o     [2];
  logic        sym_stb_o  [2];
  logic        in_ready_o [2];
  logic [2:0]  lvl_o      [2];

  rf_fsk_tx #(.BPS(1), .SYM_CNT(SYM), .FIFO_DEPTH(DEPTH)) dut0 (
    .clk(clk), .rst(rst_v[0]), .in_data(in_data_v[0]), .in_valid(in_valid_v[0]),
    .in_ready(in_ready_o[0]), .cfg_we(cfg_we_v[0]), .cfg_addr(cfg_addr_v[0][0:0]),
    .cfg_data(cfg_data_v[0]), .rf(rf_o[0]), .busy(busy_o[0]), .sym_stb(sym_stb_o[0]),
    .fifo_level(lvl_o[0]));

  rf_fsk_tx #(.BPS(2), .SYM_CNT(SYM), .FIFO_DEPTH(DEPTH)) dut1 (
    .clk(clk), .rst(rst_v[1]), .in_data(in_data_v[1]), .in_valid(in_valid_v[1]),
    .in_ready(in_ready_o[1]), .cfg_we(cfg_we_v[1]), .cfg_addr(cfg_addr_v[1]),
    .cfg_data(cfg_data_v[1]), .rf(rf_o[1]), .busy(busy_o[1]), .sym_stb(sym_stb_o[1]),
    .fifo_level(lvl_o[1]));

  int nvec = 0;
  int nerr = 0;
  bit chk_en = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Model: FIFO contents, and for the byte on air the cycle offset p since its first symbol.
  logic [7:0]  m_fifo [2][DEPTH];
  int          m_cnt  [2];
  bit          m_busy [2];
  logic [7:0]  m_byte [2];
  int          m_p    [2];
  logic [23:0] m_tacc [2];
  logic [23:0] m_cacc [2];
  logic [23:0] m_tone [2][16];
  bit          m_rf   [2];
  int          mb, mn, mi, mh;

  task automatic pop_m(input int u);
    m_byte[u] = m_fifo[u][0];
    for (int k = 0; k < DEPTH - 1; k++) m_fifo[u][k] = m_fifo[u][k+1];
    m_cnt[u]--;
  endtask

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      mb = u + 1;
      mn = 8 / mb;
      if (rst_v[u]) begin
        m_cnt[u] = 0; m_busy[u] = 0; m_p[u] = 0; m_byte[u] = 0;
        m_tacc[u] = 0; m_cacc[u] = 0; m_rf[u] = 0;
        for (int k = 0; k < (1 << mb); k++) m_tone[u][k] = 24'(5033 + k * 4194);
      end else begin
        mi = m_busy[u] ? ((int'(m_byte[u]) >> (mb * (m_p[u] / SYM))) & ((1 << mb) - 1)) : 0;
        m_rf[u]   = m_tacc[u][23] ^ m_cacc[u][23];
        m_tacc[u] = m_tacc[u] + m_tone[u][mi];
        m_cacc[u] = m_cacc[u] + CAR;
        mh = m_cnt[u];
        if (!m_busy[u]) begin
          if (mh > 0) begin pop_m(u); m_busy[u] = 1; m_p[u] = 0; end
        end else if (m_p[u] == mn * SYM - 1) begin
          if (mh > 0) begin pop_m(u); m_p[u] = 0; end
          else m_busy[u] = 0;
        end else begin
          m_p[u]++;
        end
        if (in_valid_v[u] && mh < DEPTH) begin
          m_fifo[u][m_cnt[u]] = in_data_v[u];
          m_cnt[u]++;
        end
        if (cfg_we_v[u]) m_tone[u][int'(cfg_addr_v[u]) & ((1 << mb) - 1)] = cfg_data_v[u];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int u = 0; u < 2; u++) begin
        cmp($sformatf("u%0d_in_ready", u), 32'(in_ready_o[u]), 32'(m_cnt[u] < DEPTH));
        cmp($sformatf("u%0d_fifo_level", u), 32'(lvl_o[u]), 32'(m_cnt[u]));
        cmp($sformatf("u%0d_busy", u), 32'(busy_o[u]), 32'(m_busy[u]));
        cmp($sformatf("u%0d_sym_stb", u), 32'(sym_stb_o[u]), 32'(m_busy[u] && (m_p[u] % SYM == 0)));
        cmp($sformatf("u%0d_rf", u), 32'(rf_o[u]), 32'(m_rf[u]));
      end
    end
  end

  int idx_log  [2][64];
  int stb_cyc  [2][64];
  int n_stb    [2];
  int busy_cnt [2];
  int max_lvl  [2];

  always @(negedge clk) begin
    if (sym_stb_o[0] === 1'b1 && n_stb[0] < 64) begin
      idx_log[0][n_stb[0]] = int'(dut0.tone_idx);
      stb_cyc[0][n_stb[0]] = cyc;
      n_stb[0]++;
    end
    if (sym_stb_o[1] === 1'b1 && n_stb[1] < 64) begin
      idx_log[1][n_stb[1]] = int'(dut1.tone_idx);
      stb_cyc[1][n_stb[1]] = cyc;
      n_stb[1]++;
    end
    for (int u = 0; u < 2; u++) begin
      if (busy_o[u] === 1'b1) busy_cnt[u]++;
      if (int'(lvl_o[u]) > max_lvl[u]) max_lvl[u] = int'(lvl_o[u]);
    end
  end

  task automatic clear(input int u);
    n_stb[u] = 0; busy_cnt[u] = 0; max_lvl[u] = 0;
  endtask

  // Called on a falling edge; returns on the falling edge after the byte was taken.
  task automatic push(input int u, input logic [7:0] b, output int n);
    n = 0;
    in_valid_v[u] = 1'b1;
    in_data_v[u]  = b;
    while (in_ready_o[u] !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) cmp("push_timeout", 32'(n), 32'(0));
    @(negedge clk);
    in_valid_v[u] = 1'b0;
  endtask

  task automatic wait_idle(input int u, input string nm);
    int n;
    n = 0;
    while (busy_o[u] !== 1'b0 && n < 400) begin @(negedge clk); n++; end
    if (n >= 400) cmp(nm, 32'(busy_o[u]), 32'(0));
  endtask

  task automatic check_spacing(input int u, input string nm);
    bit ok;
    ok = 1;
    for (int i = 1; i < n_stb[u]; i++) if (stb_cyc[u][i] - stb_cyc[u][i-1] != SYM) ok = 0;
    cmp(nm, 32'(ok), 32'(1));
  endtask

  logic [7:0] bytes [6];
  logic [7:0] b;
  int         w;
  int         w5;
  int         n;
  logic       rs [8];
  int         exp12 [4];

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst_v[u] = 1'b1; in_valid_v[u] = 1'b0; in_data_v[u] = '0;
      cfg_we_v[u] = 1'b0; cfg_addr_v[u] = '0; cfg_data_v[u] = '0;
    end
    repeat (2) @(negedge clk);
    rst_v[0] = 1'b0; rst_v[1] = 1'b0;
    chk_en = 1;
    cmp("reset_level", 32'(lvl_o[0]), 32'(0));
    cmp("reset_ready", 32'(in_ready_o[0]), 32'(1));
    cmp("reset_busy", 32'(busy_o[0]), 32'(0));
    cmp("reset_rf", 32'(rf_o[0]), 32'(0));

    // Single byte 0xA5: tone indices 1,0,1,0,0,1,0,1
    clear(0);
    push(0, 8'hA5, w);
    repeat (40) @(negedge clk);
    cmp("a5_nstb", 32'(n_stb[0]), 32'(8));
    b = 8'hA5;
    for (int i = 0; i < 8; i++) cmp($sformatf("a5_idx%0d", i), 32'(idx_log[0][i]), 32'(b[i]));
    check_spacing(0, "a5_stb_spacing");
    cmp("a5_busy_cycles", 32'(busy_cnt[0]), 32'(32));
    cmp("a5_back_idle", 32'(busy_o[0]), 32'(0));

    // Fill the FIFO while a lead byte is on air; the 5th byte must stall.
    bytes[0] = 8'h11; bytes[1] = 8'h3C; bytes[2] = 8'h81;
    bytes[3] = 8'hF0; bytes[4] = 8'h5A; bytes[5] = 8'hC3;
    clear(0);
    w5 = 0;
    for (int i = 0; i < 6; i++) begin
      push(0, bytes[i], w);
      if (i == 5) w5 = w;
    end
    cmp("full_held_5th", 32'(w5 > 0), 32'(1));
    cmp("full_max_level", 32'(max_lvl[0]), 32'(4));
    wait_idle(0, "b2b_idle_timeout");
    cmp("b2b_nstb", 32'(n_stb[0]), 32'(48));
    cmp("b2b_busy_cycles", 32'(busy_cnt[0]), 32'(192));
    check_spacing(0, "b2b_no_gap");
    for (int i = 0; i < 48; i++) begin
      b = bytes[i / 8];
      cmp($sformatf("b2b_idx%0d", i), 32'(idx_log[0][i]), 32'(b[i % 8]));
    end

    // Push coinciding with the pop at level 2
    bytes[0] = 8'h96; bytes[1] = 8'h69; bytes[2] = 8'hE1; bytes[3] = 8'h2D;
    clear(0);
    for (int i = 0; i < 3; i++) push(0, bytes[i], w);
    n = 0;
    while (!(m_busy[0] && m_p[0] == 8 * SYM - 1) && n < 100) begin @(negedge clk); n++; end
    cmp("pp_sync", 32'(n < 100), 32'(1));
    cmp("pp_level_before", 32'(lvl_o[0]), 32'(2));
    in_valid_v[0] = 1'b1; in_data_v[0] = bytes[3];
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    cmp("pp_level_after", 32'(lvl_o[0]), 32'(2));
    wait_idle(0, "pp_idle_timeout");
    cmp("pp_nstb", 32'(n_stb[0]), 32'(32));
    for (int i = 0; i < 32; i++) begin
      b = bytes[i / 8];
      cmp($sformatf("pp_idx%0d", i), 32'(idx_log[0][i]), 32'(b[i % 8]));
    end

    // Zero tones: rf follows the carrier MSB, period 4
    cfg_we_v[0] = 1'b1; cfg_addr_v[0] = 2'd0; cfg_data_v[0] = 24'h0;
    @(negedge clk);
    cfg_addr_v[0] = 2'd1;
    @(negedge clk);
    cfg_we_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) begin rs[i] = rf_o[0]; @(negedge clk); end
    for (int i = 0; i < 6; i++) cmp($sformatf("car_rf_toggle%0d", i), 32'(rs[i+2] != rs[i]), 32'(1));
    // Half-scale tone 0: tone phase MSB flips every cycle from the cycle after the write
    cfg_we_v[0] = 1'b1; cfg_addr_v[0] = 2'd0; cfg_data_v[0] = 24'h800000;
    @(negedge clk);
    cfg_we_v[0] = 1'b0;
    for (int i = 0; i < 7; i++) begin rs[i] = dut0.tone_acc_q[23]; @(negedge clk); end
    for (int i = 0; i < 6; i++) cmp($sformatf("tone_msb_toggle%0d", i), 32'(rs[i+1] != rs[i]), 32'(1));

    // Reset during the 3rd symbol with a second byte still queued
    rst_v[0] = 1'b1;
    @(negedge clk);
    rst_v[0] = 1'b0;
    clear(0);
    push(0, 8'hFF, w);
    push(0, 8'h0F, w);
    n = 0;
    while (n_stb[0] < 3 && n < 100) begin @(negedge clk); n++; end
    cmp("rst_sync", 32'(n < 100), 32'(1));
    @(negedge clk);
    rst_v[0] = 1'b1;
    @(negedge clk);
    rst_v[0] = 1'b0;
    cmp("midrst_busy", 32'(busy_o[0]), 32'(0));
    cmp("midrst_level", 32'(lvl_o[0]), 32'(0));
    cmp("midrst_rf", 32'(rf_o[0]), 32'(0));
    clear(0);
    repeat (20) @(negedge clk);
    cmp("midrst_no_stb", 32'(n_stb[0]), 32'(0));
    cmp("midrst_no_busy", 32'(busy_cnt[0]), 32'(0));

    // BPS=2: 0x1B -> 3,2,1,0
    exp12[0] = 3; exp12[1] = 2; exp12[2] = 1; exp12[3] = 0;
    clear(1);
    push(1, 8'h1B, w);
    repeat (24) @(negedge clk);
    cmp("bps2_nstb", 32'(n_stb[1]), 32'(4));
    for (int i = 0; i < 4; i++) cmp($sformatf("bps2_idx%0d", i), 32'(idx_log[1][i]), 32'(exp12[i]));
    check_spacing(1, "bps2_stb_spacing");
    cmp("bps2_busy_cycles", 32'(busy_cnt[1]), 32'(16));

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end
endmodule
